fx_writeback_stage: RTL and testbench
=====================================

# fx_writeback_stage

Completion stage directly downstream of the fixed-point unit. Captures each FX result, resolves the CR0 field and the fixed-point exception register (SO/OV/CA/OV32/CA32), and buffers completed results in a small in-order FIFO. The FIFO drains to the register-file writeback port through a valid/ready handshake. Dispatch uses `stall_o` to throttle FX issue.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `FXUnitCode`, 0, unit code accepted on `functionalUnitCode_i`.

Ports:
- `clock_i` in 1: single clock; all state on its rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `outputEnable_i` in 1: FX result valid this cycle.
- `functionalUnitCode_i` in 2: producer unit ID.
- `is64Bit_i` in 1: 64-bit mode for CR0 evaluation.
- `regWritebackAddress_i` in 6: destination GPR.
- `regWritebackVal_i` in 64: result, `[0:63]`, bit 0 MSB.
- `conditionRegWriteEnable_i` in 1: record form; CR0 is written.
- `caWrite_i` in 1, `carry_i` in 1: update CA/CA32 with `carry_i`.
- `ovWrite_i` in 1, `ov_i` in 1: update OV/OV32 with `ov_i`; SO is sticky-ORed.
- `xerWrite_i` in 1, `xerWriteVal_i` in 64: full exception-register write (mtspr).
- `stall_o` out 1: tells dispatch to stop issuing FX ops.
- `dropError_o` out 1: sticky flag; a result was lost.
- `xer_o` out 64: current exception register.
- `wbValid_o` out 1, `wbReady_i` in 1: writeback handshake.
- `wbAddress_o` out 6, `wbVal_o` out 64, `wbIs64Bit_o` out 1.
- `wbCrWrite_o` out 1, `wbCr_o` out 4: CR0 bits in order LT, GT, EQ, SO.

## Operation
- **Accept.** An input is accepted when `outputEnable_i` is 1, `functionalUnitCode_i == FXUnitCode`, and either count < DEPTH or a dequeue happens in the same cycle.
- **Drop.** A valid FX input that cannot be accepted is discarded and sets `dropError_o`. Only reset clears `dropError_o`.
- **Dequeue.** Occurs when `wbValid_o & wbReady_i`. `wbValid_o` = count ≠ 0. The head-entry fields drive `wb*_o` directly from storage.
- **Exception-register update at accept.** Reserved bits always read 0.
  - With `caWrite_i`: bit 34 (CA) and bit 45 (CA32) ← `carry_i`.
  - With `ovWrite_i`: bit 33 (OV) and bit 44 (OV32) ← `ov_i`; bit 32 (SO) ← SO | `ov_i`.
- **xerWrite_i.** Loads bits 32, 33, 34, 44, 45 from `xerWriteVal_i`. If it coincides with an accept, `xerWrite_i` wins completely.
- **CR0 at accept.**
  - The sign/zero test covers `val[0:63]` when `is64Bit_i` is 1, otherwise `val[32:63]`.
  - LT = negative; GT = positive and nonzero; EQ = zero. Exactly one of the three is set.
  - SO = the post-update SO value from the same cycle.
  - The computed CR0 is stored with the entry; `wbCrWrite_o` is the stored `conditionRegWriteEnable_i`.
- **Pointers.** Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- **Simultaneous accept and dequeue.** Count is unchanged. On a full FIFO this is legal: the freed slot is reused.
- **stall_o.** Asserted when count ≥ DEPTH−1. This covers the one operation already in flight in the FX unit.

## Timing
- An accept at edge N appears on `wbValid_o`/`wb*_o` after edge N, provided the FIFO was empty. Latency is 1 cycle.
- `xer_o` reflects an update in the cycle after the accepting edge.
- Entries leave strictly in accept order. With `wbReady_i` held high, throughput is 1 per cycle.
- `wb*_o` data is stable while `wbValid_o & !wbReady_i`.
- **Reset asserted:** all of the following immediately clear to 0, including mid-drain; stored entries are discarded.
  - pointers, count, `xer_o`
  - `wbValid_o`, `stall_o`, `dropError_o`, `wbCrWrite_o`
  - `wbCr_o` = 0000
- **Reset deassertion:** the first accept is possible at the next rising edge.

## Configuration
- `FX_WB_FORWARD_EN` defined:
  - adds outputs `fwdValid_o` (1), `fwdAddress_o` (6) and `fwdVal_o` (64);
  - they are registered copies of the most recently accepted entry;
  - `fwdValid_o` is 1 for exactly the cycle after each accept, for operand bypass at dispatch;
  - reset value 0.
- Undefined: those ports and their registers do not exist; the rest of the behaviour is identical.

## Test plan
- **Single accept.** Empty FIFO, `wbReady_i`=1; accept addr 5, val 0xFFFF_FFFF_FFFF_FFFE, 64-bit, CR write → next cycle `wbValid_o`=1, `wbAddress_o`=5, `wbCr_o`=1000, then `wbValid_o`=0.
- **32-bit CR0.** Accept val 0x0000_0001_0000_0000 with `is64Bit_i`=0 → `wbCr_o`=0010 (EQ); the same value with `is64Bit_i`=1 → 0100.
- **Backpressure and drop.**
  - `wbReady_i`=0; accept 3 ops with DEPTH=4 → `stall_o`=1.
  - The 4th op is accepted → count 4.
  - A 5th op is dropped → `dropError_o`=1.
  - Then `wbReady_i`=1 → 4 entries drain in order.
- **Exception register.**
  - `ovWrite_i`, `ov_i`=1 → `xer_o` bits 32, 33, 44 = 1.
  - Next op with `ov_i`=0 → bits 33, 44 = 0, bit 32 stays 1; CR0 SO=1.
  - `xerWrite_i` with 0 in the same cycle as a `caWrite_i` accept → all bits 0.
- **Full with simultaneous accept and dequeue.** FIFO full, `wbReady_i`=1 plus an accept in the same cycle → no drop, count stays 4.
- **Reset mid-drain.** Pulse `reset_i` low mid-drain → outputs clear asynchronously, before the next edge; after release, an accept returns with 1-cycle latency.

Source files
------------

// File: rtl/fx_writeback_stage.sv
// fx_writeback_stage
//
// Completion stage that sits right after the fixed-point unit. Each FX result
// is captured together with its resolved CR0 field, the fixed-point exception
// register (SO/OV/CA/OV32/CA32) is updated, and completed results queue in a
// small in-order FIFO that drains to the register-file writeback port through
// a valid/ready handshake.
//
// Optional feature macro: FX_WB_FORWARD_EN
//   When defined, adds fwdValid_o / fwdAddress_o / fwdVal_o. These are
//   registered copies of the most recently accepted result, used for operand
//   bypass at dispatch.
//
// Ports
//   clock_i, reset_i          : clock, asynchronous active-low reset
//   outputEnable_i            : FX result valid this cycle
//   functionalUnitCode_i      : producer unit ID, must equal FXUnitCode
//   is64Bit_i                 : 64-bit mode for the CR0 sign/zero test
//   regWritebackAddress_i/Val : destination GPR and result ([0:63], bit 0 MSB)
//   conditionRegWriteEnable_i : record form, CR0 is written
//   caWrite_i/carry_i         : update CA/CA32
//   ovWrite_i/ov_i            : update OV/OV32, SO accumulates
//   xerWrite_i/xerWriteVal_i  : full exception-register write (mtspr)
//   stall_o                   : throttles FX issue at dispatch
//   dropError_o               : sticky, a result was lost
//   xer_o                     : current exception register
//   wbValid_o/wbReady_i       : writeback handshake
//   wbAddress_o/wbVal_o/wbIs64Bit_o/wbCrWrite_o/wbCr_o : head-entry fields
//                               (wbCr_o = {LT, GT, EQ, SO})

module fx_writeback_stage #(
    parameter int         DEPTH      = 4,
    parameter logic [1:0] FXUnitCode = 2'd0
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        outputEnable_i,
    input  logic [1:0]  functionalUnitCode_i,
    input  logic        is64Bit_i,
    input  logic [5:0]  regWritebackAddress_i,
    input  logic [0:63] regWritebackVal_i,
    input  logic        conditionRegWriteEnable_i,
    input  logic        caWrite_i,
    input  logic        carry_i,
    input  logic        ovWrite_i,
    input  logic        ov_i,
    input  logic        xerWrite_i,
    input  logic [0:63] xerWriteVal_i,
    output logic        stall_o,
    output logic        dropError_o,
    output logic [0:63] xer_o,
`ifdef FX_WB_FORWARD_EN
    output logic        fwdValid_o,
    output logic [5:0]  fwdAddress_o,
    output logic [0:63] fwdVal_o,
`endif
    output logic        wbValid_o,
    input  logic        wbReady_i,
    output logic [5:0]  wbAddress_o,
    output logic [0:63] wbVal_o,
    output logic        wbIs64Bit_o,
    output logic        wbCrWrite_o,
    output logic [3:0]  wbCr_o
);

    localparam int             PW          = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_COUNT  = (PW+1)'(DEPTH);
    localparam logic [PW:0]    STALL_COUNT = (PW+1)'(DEPTH - 1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic [5:0]  addr_mem [DEPTH];
    logic [0:63] val_mem  [DEPTH];
    logic        is64_mem [DEPTH];
    logic        crw_mem  [DEPTH];
    logic [3:0]  cr_mem   [DEPTH];

    logic xer_so, xer_ov, xer_ca, xer_ov32, xer_ca32;
    logic so_next, ov_next, ca_next, ov32_next, ca32_next;

    logic       fx_valid;
    logic       dequeue;
    logic       accept;
    logic       cr_neg;
    logic       cr_zero;
    logic [3:0] cr_next;

    // Only these five exception-register bits are architected here; the rest
    // of xerWriteVal_i is intentionally ignored.
    logic unused_xer_bits;
    assign unused_xer_bits = ^{xerWriteVal_i[0:31], xerWriteVal_i[35:43], xerWriteVal_i[46:63]};

    // A full FIFO can still take a result when the head leaves in the same
    // cycle, because the freed slot is reused immediately.
    assign fx_valid = outputEnable_i && (functionalUnitCode_i == FXUnitCode);
    assign dequeue  = wbValid_o && wbReady_i;
    assign accept   = fx_valid && ((count != FULL_COUNT) || dequeue);

    // Stall one entry early so the op already in flight in the FX unit still
    // has a slot to land in.
    assign wbValid_o = (count != '0);
    assign stall_o   = (count >= STALL_COUNT);

    // Head entry drives the writeback port straight from storage; the CR
    // fields are masked by valid so they read zero while the FIFO is empty.
    assign wbAddress_o = addr_mem[rd_ptr];
    assign wbVal_o     = val_mem[rd_ptr];
    assign wbIs64Bit_o = is64_mem[rd_ptr];
    assign wbCrWrite_o = wbValid_o && crw_mem[rd_ptr];
    assign wbCr_o      = wbValid_o ? cr_mem[rd_ptr] : 4'b0000;

    // Exception register next state. An mtspr-style full write overrides any
    // CA/OV update from a result accepted in the same cycle.
    always_comb begin
        so_next   = xer_so;
        ov_next   = xer_ov;
        ca_next   = xer_ca;
        ov32_next = xer_ov32;
        ca32_next = xer_ca32;
        if (xerWrite_i) begin
            so_next   = xerWriteVal_i[32];
            ov_next   = xerWriteVal_i[33];
            ca_next   = xerWriteVal_i[34];
            ov32_next = xerWriteVal_i[44];
            ca32_next = xerWriteVal_i[45];
        end else if (accept) begin
            if (caWrite_i) begin
                ca_next   = carry_i;
                ca32_next = carry_i;
            end
            if (ovWrite_i) begin
                ov_next   = ov_i;
                ov32_next = ov_i;
                so_next   = xer_so | ov_i;
            end
        end
    end

    // CR0 for the incoming result. In 32-bit mode only the low word counts,
    // so its sign is bit 32 in big-endian numbering. SO comes from the
    // post-update value so the entry sees this cycle's overflow.
    always_comb begin
        if (is64Bit_i) begin
            cr_neg  = regWritebackVal_i[0];
            cr_zero = (regWritebackVal_i == 64'd0);
        end else begin
            cr_neg  = regWritebackVal_i[32];
            cr_zero = (regWritebackVal_i[32:63] == 32'd0);
        end
        cr_next = {cr_neg, !cr_neg && !cr_zero, cr_zero, so_next};
    end

    // Reassemble the architected exception register; reserved bits are zero.
    always_comb begin
        xer_o     = '0;
        xer_o[32] = xer_so;
        xer_o[33] = xer_ov;
        xer_o[34] = xer_ca;
        xer_o[44] = xer_ov32;
        xer_o[45] = xer_ca32;
    end

    // FIFO storage. Contents need no reset: valid is derived from count and
    // the CR outputs are masked while empty.
    always_ff @(posedge clock_i) begin
        if (accept) begin
            addr_mem[wr_ptr] <= regWritebackAddress_i;
            val_mem[wr_ptr]  <= regWritebackVal_i;
            is64_mem[wr_ptr] <= is64Bit_i;
            crw_mem[wr_ptr]  <= conditionRegWriteEnable_i;
            cr_mem[wr_ptr]   <= cr_next;
        end
    end

    // Pointers, occupancy, exception register and the sticky drop flag.
    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            xer_so      <= 1'b0;
            xer_ov      <= 1'b0;
            xer_ca      <= 1'b0;
            xer_ov32    <= 1'b0;
            xer_ca32    <= 1'b0;
            dropError_o <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (dequeue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !dequeue) begin
                count <= count + 1'b1;
            end else if (dequeue && !accept) begin
                count <= count - 1'b1;
            end
            xer_so   <= so_next;
            xer_ov   <= ov_next;
            xer_ca   <= ca_next;
            xer_ov32 <= ov32_next;
            xer_ca32 <= ca32_next;
            if (fx_valid && !accept) begin
                dropError_o <= 1'b1;
            end
        end
    end

`ifdef FX_WB_FORWARD_EN
    // Bypass copy of the newest accepted result, valid for one cycle only.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            fwdValid_o   <= 1'b0;
            fwdAddress_o <= '0;
            fwdVal_o     <= '0;
        end else begin
            fwdValid_o <= accept;
            if (accept) begin
                fwdAddress_o <= regWritebackAddress_i;
                fwdVal_o     <= regWritebackVal_i;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fx_writeback_stage.sv
// Testbench for fx_writeback_stage (default DEPTH=4, FXUnitCode=0).
// Directed scenarios, each task drives its own stimulus and checks results
// against hand-computed values.

module tb_fx_writeback_stage;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        outputEnable_i;
    logic [1:0]  functionalUnitCode_i;
    logic        is64Bit_i;
    logic [5:0]  regWritebackAddress_i;
    logic [0:63] regWritebackVal_i;
    logic        conditionRegWriteEnable_i;
    logic        caWrite_i;
    logic        carry_i;
    logic        ovWrite_i;
    logic        ov_i;
    logic        xerWrite_i;
    logic [0:63] xerWriteVal_i;
    logic        stall_o;
    logic        dropError_o;
    logic [0:63] xer_o;
    logic        wbValid_o;
    logic        wbReady_i;
    logic [5:0]  wbAddress_o;
    logic [0:63] wbVal_o;
    logic        wbIs64Bit_o;
    logic        wbCrWrite_o;
    logic [3:0]  wbCr_o;
`ifdef FX_WB_FORWARD_EN
    logic        fwdValid_o;
    logic [5:0]  fwdAddress_o;
    logic [0:63] fwdVal_o;
`endif

    int checks = 0;
    int passes = 0;

    fx_writeback_stage dut (
        .clock_i                   (clock_i),
        .reset_i                   (reset_i),
        .outputEnable_i            (outputEnable_i),
        .functionalUnitCode_i      (functionalUnitCode_i),
        .is64Bit_i                 (is64Bit_i),
        .regWritebackAddress_i     (regWritebackAddress_i),
        .regWritebackVal_i         (regWritebackVal_i),
        .conditionRegWriteEnable_i (conditionRegWriteEnable_i),
        .caWrite_i                 (caWrite_i),
        .carry_i                   (carry_i),
        .ovWrite_i                 (ovWrite_i),
        .ov_i                      (ov_i),
        .xerWrite_i                (xerWrite_i),
        .xerWriteVal_i             (xerWriteVal_i),
        .stall_o                   (stall_o),
        .dropError_o               (dropError_o),
        .xer_o                     (xer_o),
`ifdef FX_WB_FORWARD_EN
        .fwdValid_o                (fwdValid_o),
        .fwdAddress_o              (fwdAddress_o),
        .fwdVal_o                  (fwdVal_o),
`endif
        .wbValid_o                 (wbValid_o),
        .wbReady_i                 (wbReady_i),
        .wbAddress_o               (wbAddress_o),
        .wbVal_o                   (wbVal_o),
        .wbIs64Bit_o               (wbIs64Bit_o),
        .wbCrWrite_o               (wbCrWrite_o),
        .wbCr_o                    (wbCr_o)
    );

    always #5 clock_i = ~clock_i;

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle();
        outputEnable_i            = 1'b0;
        functionalUnitCode_i      = 2'd0;
        is64Bit_i                 = 1'b0;
        regWritebackAddress_i     = 6'd0;
        regWritebackVal_i         = 64'd0;
        conditionRegWriteEnable_i = 1'b0;
        caWrite_i                 = 1'b0;
        carry_i                   = 1'b0;
        ovWrite_i                 = 1'b0;
        ov_i                      = 1'b0;
        xerWrite_i                = 1'b0;
        xerWriteVal_i             = 64'd0;
    endtask

    task automatic drive_op(input logic [5:0] addr, input logic [0:63] val,
                            input logic is64, input logic crw,
                            input logic caW, input logic carry,
                            input logic ovW, input logic ov);
        idle();
        outputEnable_i            = 1'b1;
        regWritebackAddress_i     = addr;
        regWritebackVal_i         = val;
        is64Bit_i                 = is64;
        conditionRegWriteEnable_i = crw;
        caWrite_i                 = caW;
        carry_i                   = carry;
        ovWrite_i                 = ovW;
        ov_i                      = ov;
    endtask

    task automatic test_reset();
        idle();
        wbReady_i = 1'b1;
        reset_i   = 1'b0;
        #2;
        checks++; if (wbValid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", wbValid_o); else passes++;
        checks++; if (stall_o !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", stall_o); else passes++;
        checks++; if (dropError_o !== 1'b0) $display("[TB] FAIL reset_drop: got %b expected 0", dropError_o); else passes++;
        checks++; if (xer_o !== 64'd0) $display("[TB] FAIL reset_xer: got %h expected 0", xer_o); else passes++;
        checks++; if (wbCr_o !== 4'b0000 || wbCrWrite_o !== 1'b0) $display("[TB] FAIL reset_cr: got %b/%b expected 0000/0", wbCr_o, wbCrWrite_o); else passes++;
        tick();
        tick();
        reset_i = 1'b1;
    endtask

    task automatic test_single_accept();
        wbReady_i = 1'b1;
        drive_op(6'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (wbValid_o !== 1'b1) $display("[TB] FAIL single_valid: got %b expected 1", wbValid_o); else passes++;
        checks++; if (wbAddress_o !== 6'd5) $display("[TB] FAIL single_addr: got %0d expected 5", wbAddress_o); else passes++;
        checks++; if (wbVal_o !== 64'hFFFF_FFFF_FFFF_FFFE) $display("[TB] FAIL single_val: got %h expected fffffffffffffffe", wbVal_o); else passes++;
        checks++; if (wbCr_o !== 4'b1000) $display("[TB] FAIL single_cr: got %b expected 1000", wbCr_o); else passes++;
        checks++; if (wbCrWrite_o !== 1'b1 || wbIs64Bit_o !== 1'b1) $display("[TB] FAIL single_flags: got crw=%b is64=%b expected 1/1", wbCrWrite_o, wbIs64Bit_o); else passes++;
        tick();
        checks++; if (wbValid_o !== 1'b0) $display("[TB] FAIL single_drained: got %b expected 0", wbValid_o); else passes++;
        // A result from another unit is neither accepted nor counted as a drop.
        drive_op(6'd7, 64'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        functionalUnitCode_i = 2'd2;
        tick();
        idle();
        checks++; if (wbValid_o !== 1'b0 || dropError_o !== 1'b0) $display("[TB] FAIL foreign_unit: got valid=%b drop=%b expected 0/0", wbValid_o, dropError_o); else passes++;
    endtask

    task automatic test_cr32();
        wbReady_i = 1'b1;
        drive_op(6'd6, 64'h0000_0001_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (wbCr_o !== 4'b0010) $display("[TB] FAIL cr32_eq: got %b expected 0010", wbCr_o); else passes++;
        tick();
        drive_op(6'd6, 64'h0000_0001_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (wbCr_o !== 4'b0100) $display("[TB] FAIL cr64_gt: got %b expected 0100", wbCr_o); else passes++;
        tick();
        drive_op(6'd6, 64'h0000_0000_8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (wbCr_o !== 4'b1000) $display("[TB] FAIL cr32_lt: got %b expected 1000", wbCr_o); else passes++;
        tick();
    endtask

    task automatic test_xer();
        wbReady_i = 1'b1;
        drive_op(6'd1, 64'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if (xer_o !== 64'h0000_0000_C008_0000) $display("[TB] FAIL xer_ov_set: got %h expected 00000000c0080000", xer_o); else passes++;
        checks++; if (wbCr_o !== 4'b0101) $display("[TB] FAIL xer_cr_so1: got %b expected 0101", wbCr_o); else passes++;
        drive_op(6'd2, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (xer_o !== 64'h0000_0000_8000_0000) $display("[TB] FAIL xer_so_sticky: got %h expected 0000000080000000", xer_o); else passes++;
        checks++; if (wbAddress_o !== 6'd2 || wbCr_o !== 4'b0011) $display("[TB] FAIL xer_cr_so2: got addr=%0d cr=%b expected 2/0011", wbAddress_o, wbCr_o); else passes++;
        drive_op(6'd3, 64'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (xer_o !== 64'h0000_0000_A004_0000) $display("[TB] FAIL xer_ca_set: got %h expected 00000000a0040000", xer_o); else passes++;
        drive_op(6'd4, 64'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        xerWrite_i    = 1'b1;
        xerWriteVal_i = 64'd0;
        tick();
        idle();
        checks++; if (xer_o !== 64'd0) $display("[TB] FAIL xer_write_wins: got %h expected 0", xer_o); else passes++;
        checks++; if (wbValid_o !== 1'b1 || wbAddress_o !== 6'd4) $display("[TB] FAIL xer_write_accept: got valid=%b addr=%0d expected 1/4", wbValid_o, wbAddress_o); else passes++;
        tick();
        checks++; if (wbValid_o !== 1'b0) $display("[TB] FAIL xer_drained: got %b expected 0", wbValid_o); else passes++;
    endtask

    task automatic test_full_simultaneous();
        wbReady_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_op(6'(8 + i), 64'(100 + i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        checks++; if (stall_o !== 1'b1 || wbAddress_o !== 6'd8) $display("[TB] FAIL full_state: got stall=%b head=%0d expected 1/8", stall_o, wbAddress_o); else passes++;
        wbReady_i = 1'b1;
        drive_op(6'd12, 64'd104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (dropError_o !== 1'b0) $display("[TB] FAIL full_simul_nodrop: got %b expected 0", dropError_o); else passes++;
        checks++; if (stall_o !== 1'b1) $display("[TB] FAIL full_simul_stall: got %b expected 1", stall_o); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (wbValid_o !== 1'b1 || wbAddress_o !== 6'(9 + i) || wbVal_o !== 64'(101 + i)) $display("[TB] FAIL full_drain_%0d: got valid=%b addr=%0d val=%0d expected 1/%0d/%0d", i, wbValid_o, wbAddress_o, wbVal_o, 9 + i, 101 + i); else passes++;
            tick();
        end
        checks++; if (wbValid_o !== 1'b0) $display("[TB] FAIL full_drained: got %b expected 0", wbValid_o); else passes++;
    endtask

    task automatic test_backpressure();
        wbReady_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_op(6'(1 + i), 64'(32'hA0 + i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            if (i == 1) begin
                checks++; if (stall_o !== 1'b0) $display("[TB] FAIL bp_stall_count2: got %b expected 0", stall_o); else passes++;
            end
        end
        checks++; if (stall_o !== 1'b1) $display("[TB] FAIL bp_stall_count3: got %b expected 1", stall_o); else passes++;
        drive_op(6'd4, 64'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (dropError_o !== 1'b0 || stall_o !== 1'b1) $display("[TB] FAIL bp_fourth_accept: got drop=%b stall=%b expected 0/1", dropError_o, stall_o); else passes++;
        drive_op(6'd5, 64'hA4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (dropError_o !== 1'b1) $display("[TB] FAIL bp_drop: got %b expected 1", dropError_o); else passes++;
        checks++; if (wbAddress_o !== 6'd1 || wbVal_o !== 64'hA0) $display("[TB] FAIL bp_hold: got addr=%0d val=%h expected 1/a0", wbAddress_o, wbVal_o); else passes++;
        wbReady_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (wbValid_o !== 1'b1 || wbAddress_o !== 6'(1 + i) || wbVal_o !== 64'(32'hA0 + i)) $display("[TB] FAIL bp_drain_%0d: got valid=%b addr=%0d val=%h expected 1/%0d/%h", i, wbValid_o, wbAddress_o, wbVal_o, 1 + i, 32'hA0 + i); else passes++;
            tick();
        end
        checks++; if (wbValid_o !== 1'b0 || dropError_o !== 1'b1) $display("[TB] FAIL bp_after_drain: got valid=%b drop=%b expected 0/1", wbValid_o, dropError_o); else passes++;
    endtask

    task automatic test_reset_mid_drain();
        wbReady_i = 1'b0;
        drive_op(6'd10, 64'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive_op(6'd11, 64'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_op(6'd12, 64'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        wbReady_i = 1'b1;
        tick();
        checks++; if (wbValid_o !== 1'b1 || wbAddress_o !== 6'd11 || xer_o === 64'd0) $display("[TB] FAIL mid_drain_state: got valid=%b addr=%0d xer=%h expected 1/11/nonzero", wbValid_o, wbAddress_o, xer_o); else passes++;
        #2;
        reset_i = 1'b0;
        #1;
        checks++; if (wbValid_o !== 1'b0 || stall_o !== 1'b0) $display("[TB] FAIL async_reset_fifo: got valid=%b stall=%b expected 0/0", wbValid_o, stall_o); else passes++;
        checks++; if (dropError_o !== 1'b0 || xer_o !== 64'd0) $display("[TB] FAIL async_reset_flags: got drop=%b xer=%h expected 0/0", dropError_o, xer_o); else passes++;
        checks++; if (wbCr_o !== 4'b0000 || wbCrWrite_o !== 1'b0) $display("[TB] FAIL async_reset_cr: got %b/%b expected 0000/0", wbCr_o, wbCrWrite_o); else passes++;
        tick();
        reset_i = 1'b1;
        drive_op(6'd20, 64'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (wbValid_o !== 1'b1 || wbAddress_o !== 6'd20 || wbVal_o !== 64'h55) $display("[TB] FAIL post_reset_accept: got valid=%b addr=%0d val=%h expected 1/20/55", wbValid_o, wbAddress_o, wbVal_o); else passes++;
        tick();
        checks++; if (wbValid_o !== 1'b0) $display("[TB] FAIL post_reset_drained: got %b expected 0", wbValid_o); else passes++;
    endtask

    initial begin
        test_reset();
        test_single_accept();
        test_cr32();
        test_xer();
        test_full_simultaneous();
        test_backpressure();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
